// File: rtl/tthbif_rf_pkg.sv
// tthbif_rf_pkg: shared types and constants for the tthbif UART register responder
package tthbif_rf_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_DATA, RESP} rf_state_e;
  localparam logic [6:0] ADDR_CTRL = 7'h00;
  localparam logic [6:0] ADDR_SCRATCH = 7'h01;
  localparam logic [6:0] ADDR_ID = 7'h02;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  localparam logic [7:0] CTRL_RESET = 8'hFF;
endpackage

// File: rtl/tthbif_rf_regs.sv
// tthbif_rf_regs: register storage, write decode with ACK/NAK and read mux
module tthbif_rf_regs
  import tthbif_rf_pkg::*;
#(
  parameter logic [7:0] ID_VALUE = 8'h48
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       we,
  input  logic [6:0] waddr,
  input  logic [7:0] wdata,
  input  logic [6:0] raddr,
  output logic [7:0] rdata,
  output logic [7:0] wresp,
  output logic [7:0] ctrl
);
  logic [7:0] scratch;
  assign wresp = (waddr == ADDR_CTRL || waddr == ADDR_SCRATCH) ? ACK : NAK;
  assign rdata = raddr == ADDR_CTRL    ? ctrl :
                 raddr == ADDR_SCRATCH ? scratch :
                 raddr == ADDR_ID      ? ID_VALUE : 8'h00;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl <= CTRL_RESET;
      scratch <= 8'h00;
    end else begin
      if (we && waddr == ADDR_CTRL) ctrl <= wdata;
      if (we && waddr == ADDR_SCRATCH) scratch <= wdata;
    end
  end
endmodule

// File: rtl/tthbif_uart_rf.sv
// tthbif_uart_rf: UART command decoder and response FSM for the tthbif tap-select registers
module tthbif_uart_rf
  import tthbif_rf_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0] ID_VALUE = 8'h48
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       rx_data_valid_i,
  input  logic [7:0] rx_data_i,
  input  logic       tx_data_ready_i,
  output logic       tx_data_valid_o,
  output logic [7:0] tx_data_o,
  output logic [1:0] rx_flop_tap_sel_o,
  output logic [1:0] rx_comb_tap_sel_o,
  output logic [1:0] tx_flop_tap_sel_o,
  output logic [1:0] tx_comb_tap_sel_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  rf_state_e state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [6:0] addr, addr_nxt;
  logic [7:0] tx_data_nxt, rdata, wresp, ctrl;
  logic rx, we, timed_out;
  assign rx = en_i && rx_data_valid_i;
  assign timed_out = cnt >= CW'(TIMEOUT_CYCLES - 1);
  assign tx_data_valid_o = state == RESP;
  assign {tx_comb_tap_sel_o, tx_flop_tap_sel_o, rx_comb_tap_sel_o, rx_flop_tap_sel_o} = ctrl;
  tthbif_rf_regs #(.ID_VALUE(ID_VALUE)) u_regs (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .we    (we),
    .waddr (addr),
    .wdata (rx_data_i),
    .raddr (rx_data_i[6:0]),
    .rdata (rdata),
    .wresp (wresp),
    .ctrl  (ctrl)
  );
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    addr_nxt = addr;
    tx_data_nxt = tx_data_o;
    we = 1'b0;
    case (state)
      IDLE: if (rx) begin
        state_nxt = rx_data_i[7] ? WAIT_DATA : RESP;
        addr_nxt = rx_data_i[7] ? rx_data_i[6:0] : addr;
        cnt_nxt = '0;
        tx_data_nxt = rx_data_i[7] ? tx_data_o : rdata;
      end
      WAIT_DATA: if (rx) begin
        we = 1'b1;
        tx_data_nxt = wresp;
        state_nxt = RESP;
      end else begin
        state_nxt = timed_out ? IDLE : WAIT_DATA;
        cnt_nxt = cnt + 1'b1;
      end
      RESP: state_nxt = tx_data_ready_i ? IDLE : RESP;
      default: state_nxt = IDLE;
    endcase
    if (!en_i) state_nxt = IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt <= '0;
      addr <= '0;
      tx_data_o <= 8'h00;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      addr <= addr_nxt;
      tx_data_o <= tx_data_nxt;
    end
  end
endmodule

// File: tb/tb_tthbif_uart_rf.sv
// tb_tthbif_uart_rf: directed scoreboard bench for the tthbif UART register responder
module tb_tthbif_uart_rf;
  logic clk = 1'b0;
  logic rst_n, en, rx_valid, tx_ready, tx_valid;
  logic [7:0] rx_data, tx_data, d0, e;
  logic [1:0] rx_flop, rx_comb, tx_flop, tx_comb;
  logic [7:0] exp_q[$];
  logic stable, seen;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  tthbif_uart_rf #(.TIMEOUT_CYCLES(8), .ID_VALUE(8'h48)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .en_i             (en),
    .rx_data_valid_i  (rx_valid),
    .rx_data_i        (rx_data),
    .tx_data_ready_i  (tx_ready),
    .tx_data_valid_o  (tx_valid),
    .tx_data_o        (tx_data),
    .rx_flop_tap_sel_o(rx_flop),
    .rx_comb_tap_sel_o(rx_comb),
    .tx_flop_tap_sel_o(tx_flop),
    .tx_comb_tap_sel_o(tx_comb)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1 rx_valid = 1'b1;
    rx_data = b;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask
  task automatic send_after(input logic [7:0] b, input int n);
    repeat (n - 2) @(posedge clk);
    send_byte(b);
  endtask
  task automatic get_resp(input string tag);
    int n = 0;
    logic [7:0] x;
    while (!tx_valid && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    chk({tag, "_valid"}, 8'(tx_valid), 8'h01);
    x = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
    chk(tag, tx_data, x);
    @(posedge clk);
    #1 chk({tag, "_done"}, 8'(tx_valid), 8'h00);
  endtask
  task automatic quiet(input string tag, input int n);
    seen = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1 seen |= tx_valid;
    end
    chk(tag, 8'(seen), 8'h00);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 1'b0; en = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("rst_valid", 8'(tx_valid), 8'h00);
    chk("rst_data", tx_data, 8'h00);
    chk("rst_taps", {tx_comb, tx_flop, rx_comb, rx_flop}, 8'hFF);
    rst_n = 1'b1;
    exp_q.push_back(8'hFF);
    send_byte(8'h00);
    chk("latency", 8'(tx_valid), 8'h01);
    get_resp("rd_ctrl_rst");
    exp_q.push_back(8'h06);
    send_byte(8'h80);
    send_byte(8'h1B);
    chk("wr_visible", {tx_comb, tx_flop, rx_comb, rx_flop}, 8'h1B);
    get_resp("wr_ctrl_ack");
    chk("rx_flop", 8'(rx_flop), 8'd3);
    chk("rx_comb", 8'(rx_comb), 8'd2);
    chk("tx_flop", 8'(tx_flop), 8'd1);
    chk("tx_comb", 8'(tx_comb), 8'd0);
    exp_q.push_back(8'h1B);
    send_byte(8'h00);
    get_resp("rd_ctrl_new");
    exp_q.push_back(8'h15);
    send_byte(8'h82);
    send_byte(8'h00);
    get_resp("wr_id_nak");
    exp_q.push_back(8'h48);
    send_byte(8'h02);
    get_resp("rd_id");
    exp_q.push_back(8'h00);
    send_byte(8'h7F);
    get_resp("rd_unmapped");
    tx_ready = 1'b0;
    exp_q.push_back(8'h00);
    send_byte(8'h01);
    d0 = tx_data;
    stable = tx_valid;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin rx_valid = 1'b1; rx_data = 8'h00; end
      if (i == 6) rx_valid = 1'b0;
      @(posedge clk);
      #1 stable &= tx_valid && tx_data === d0;
    end
    chk("stall_stable", 8'(stable), 8'h01);
    chk("stall_data", d0, exp_q.pop_front());
    tx_ready = 1'b1; rx_valid = 1'b1; rx_data = 8'h00;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    chk("stall_hs", 8'(tx_valid), 8'h00);
    quiet("stall_no_extra", 6);
    exp_q.push_back(8'h00);
    send_byte(8'h81);
    send_after(8'h01, 9);
    get_resp("to_late_read");
    exp_q.push_back(8'h06);
    send_byte(8'h81);
    send_after(8'h5A, 8);
    get_resp("to_edge_ack");
    exp_q.push_back(8'h5A);
    send_byte(8'h01);
    get_resp("to_edge_rd");
    send_byte(8'h80);
    en = 1'b0;
    @(posedge clk);
    #1 chk("en_wait_valid", 8'(tx_valid), 8'h00);
    send_byte(8'h80);
    send_byte(8'h00);
    chk("en_ignore", 8'(tx_valid), 8'h00);
    en = 1'b1;
    exp_q.push_back(8'h1B);
    send_byte(8'h00);
    get_resp("en_wait_hold");
    tx_ready = 1'b0;
    send_byte(8'h01);
    chk("en_resp_data", tx_data, 8'h5A);
    en = 1'b0;
    chk("en_resp_same", 8'(tx_valid), 8'h01);
    @(posedge clk);
    #1 chk("en_resp_drop", 8'(tx_valid), 8'h00);
    en = 1'b1; tx_ready = 1'b1;
    quiet("en_resp_quiet", 4);
    exp_q.push_back(8'h5A);
    send_byte(8'h01);
    get_resp("en_scratch_hold");
    send_byte(8'h81);
    rst_n = 1'b0;
    #2 chk("rst_wait_valid", 8'(tx_valid), 8'h00);
    chk("rst_wait_taps", {tx_comb, tx_flop, rx_comb, rx_flop}, 8'hFF);
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.push_back(8'h00);
    send_byte(8'h01);
    get_resp("rst_scratch");
    tx_ready = 1'b0;
    send_byte(8'h00);
    chk("rst_resp_pre", 8'(tx_valid), 8'h01);
    rst_n = 1'b0;
    #2 chk("rst_resp_valid", 8'(tx_valid), 8'h00);
    chk("rst_resp_data", tx_data, 8'h00);
    @(posedge clk);
    #1 rst_n = 1'b1; tx_ready = 1'b1;
    quiet("rst_resp_quiet", 4);
    chk("queue_empty", 8'(exp_q.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
